// File: rtl/btn_cond_pkg.sv
// Shared definitions for the arrow-pad button conditioner.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package btn_cond_pkg;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 0;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-channel synchroniser, debouncer and press/release pulse generator.
// Latency: level and pulse change DEBOUNCE_CYCLES+2 edges after a stable new input is first sampled.
// Backpressure: none; pulses are one-cycle strobes with no ready handshake. Repeat pulses under BTN_COND_REPEAT_EN.
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef BTN_COND_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;
    logic          release_q;
    logic          settle;
    logic          rise;
    logic          fall;
    logic          press_next;

    // The level flips on the edge that sees the last of DEBOUNCE_CYCLES mismatching samples.
    assign settle = (s2 != level_q) && (cnt_q == CNT_MAX);
    assign rise   = settle &  s2;
    assign fall   = settle & ~s2;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // Count consecutive mismatches; any matching sample restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (s2 == level_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == CNT_MAX) begin
            level_q <= s2;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

`ifdef BTN_COND_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX);
    localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q;
    logic          rfirst_q;
    logic          rep_fire;

    // A repeat never coincides with the falling edge, so press and release stay exclusive.
    assign rep_fire = level_q && !fall &&
                      (rfirst_q ? (rcnt_q == RDLY_LAST) : (rcnt_q == RPER_LAST));

    // Repeat timer: initial delay after the press, then a fixed period while held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
        end else if (!level_q) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
        end else if (rep_fire) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_q + 1'b1;
        end
    end

    assign press_next = rise | rep_fire;
`else
    assign press_next = rise;
`endif

    // Pulses are registered on the same edge the level changes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_next;
            release_q <= fall;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_cond.sv
// Four-channel arrow-pad conditioner: optional inversion, sync, debounce, press/release pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling a stable new pad value to level/pulse.
// Backpressure: none; outputs are levels and one-cycle strobes. Auto-repeat when BTN_COND_REPEAT_EN is defined.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_BTNS-1:0] btn_raw_i,
    output logic [NUM_BTNS-1:0] btn_level_o,
    output logic [NUM_BTNS-1:0] btn_press_o,
    output logic [NUM_BTNS-1:0] btn_release_o
);

    btn_vec_t btn_act;

    // Normalise to 1 = pressed before the synchronisers.
    assign btn_act = (ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_COND_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .btn_i     (btn_act[i]),
            .level_o   (btn_level_o[i]),
            .press_o   (btn_press_o[i]),
            .release_o (btn_release_o[i])
        );
    end

`ifndef BTN_COND_REPEAT_EN
    // Repeat timing has no effect in this build.
    logic [63:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

endmodule
